// File: rtl/uart_rx_controller.sv
// UART receiver control: sequences Rx_EN/baud_select around baud changes and
// buffers received frames with their error flags in a small FWFT FIFO.
//
// state   | meaning
// IDLE    | receiver disabled, waiting for cfg_enable
// RUN     | receiver enabled, frames accepted
// QUIESCE | receiver held off while the quiesce timer counts down
// APPLY   | new baud code latched, receiver still off for this cycle
module uart_rx_controller #(
    parameter int FIFO_DEPTH     = 4,
    parameter int QUIESCE_CYCLES = 16
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         cfg_enable,
    input  logic [2:0]                   cfg_baud,
    input  logic                         cfg_drop_errors,
    input  logic                         Rx_VALID,
    input  logic                         Rx_PERROR,
    input  logic                         Rx_FERROR,
    input  logic [7:0]                   Rx_DATA,
    output logic                         Rx_EN,
    output logic [2:0]                   baud_select,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic [1:0]                   rd_err,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         overrun,
    output logic [7:0]                   perr_cnt,
    output logic [7:0]                   ferr_cnt,
    input  logic                         clr_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int QW = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, QUIESCE, APPLY} state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [2:0]    baud_n;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            qcnt        <= '0;
            baud_select <= 3'b000;
        end else begin
            state       <= state_n;
            qcnt        <= qcnt_n;
            baud_select <= baud_n;
        end
    end

    always_comb begin
        state_n = state;
        qcnt_n  = qcnt;
        baud_n  = baud_select;
        case (state)
            IDLE: begin
                if (cfg_enable) begin
                    baud_n  = cfg_baud;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!cfg_enable) begin
                    state_n = IDLE;
                end else if (cfg_baud != baud_select) begin
                    state_n = QUIESCE;
                    qcnt_n  = QW'(QUIESCE_CYCLES - 1);
                end
            end
            QUIESCE: begin
                if (!cfg_enable) begin
                    state_n = IDLE;
                end else if (qcnt == '0) begin
                    state_n = APPLY;
                end else begin
                    qcnt_n = qcnt - QW'(1);
                end
            end
            APPLY: begin
                baud_n  = cfg_baud;
                state_n = cfg_enable ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign Rx_EN = (state == RUN);

    logic       any_q;
    logic       any_now, accept, wr_cand, pop, ovf, wr;
    logic [9:0] wdata;

    assign any_now = Rx_VALID | Rx_PERROR | Rx_FERROR;
    assign accept  = any_now & ~any_q & (state == RUN);
    assign wr_cand = accept & ~(cfg_drop_errors & (Rx_PERROR | Rx_FERROR));
    assign pop     = rd_en & ~empty;
    assign ovf     = wr_cand & full & ~pop;
    assign wr      = wr_cand & ~ovf;
    assign wdata   = {Rx_FERROR, Rx_PERROR, Rx_DATA};

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_n;
    logic [CW-1:0] count_n;
    logic [9:0]    head_n;

    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));
    assign rptr_n = pop ? rptr + AW'(1) : rptr;

    always_comb begin
        count_n = count;
        if (wr && !pop)
            count_n = count + CW'(1);
        else if (!wr && pop)
            count_n = count - CW'(1);
    end

    // The incoming word becomes the head when nothing older survives this cycle.
    always_comb begin
        head_n = {rd_err, rd_data};
        if (count_n != '0) begin
            if (wr && ((count == '0) || (pop && count == CW'(1))))
                head_n = wdata;
            else
                head_n = mem[rptr_n];
        end
    end

    always_ff @(posedge Clk) begin
        if (wr)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= 8'h00;
            rd_err  <= 2'b00;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            rptr              <= rptr_n;
            count             <= count_n;
            {rd_err, rd_data} <= head_n;
        end
    end

    logic [7:0] perr_n, ferr_n;

    always_comb begin
        perr_n = clr_status ? 8'h00 : perr_cnt;
        ferr_n = clr_status ? 8'h00 : ferr_cnt;
        if (accept && Rx_PERROR && perr_n != 8'hFF)
            perr_n = perr_n + 8'd1;
        if (accept && Rx_FERROR && ferr_n != 8'hFF)
            ferr_n = ferr_n + 8'd1;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            any_q    <= 1'b0;
            overrun  <= 1'b0;
            perr_cnt <= 8'h00;
            ferr_cnt <= 8'h00;
        end else begin
            any_q    <= any_now;
            overrun  <= (overrun & ~clr_status) | ovf;
            perr_cnt <= perr_n;
            ferr_cnt <= ferr_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: directed sequencing steps plus a random phase
// checked against a queue-based model of the frame buffer and status.
module tb_uart_rx_controller;

    localparam int DEPTH = 4;
    localparam int QC    = 16;

    logic       Clk = 1'b0;
    logic       reset, cfg_enable, cfg_drop_errors;
    logic [2:0] cfg_baud;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR;
    logic [7:0] Rx_DATA;
    logic       Rx_EN;
    logic [2:0] baud_select;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [1:0] rd_err;
    logic       empty, full;
    logic [2:0] count;
    logic       overrun;
    logic [7:0] perr_cnt, ferr_cnt;
    logic       clr_status;

    uart_rx_controller #(.FIFO_DEPTH(DEPTH), .QUIESCE_CYCLES(QC)) dut (
        .Clk(Clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_baud(cfg_baud),
        .cfg_drop_errors(cfg_drop_errors), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR),
        .Rx_FERROR(Rx_FERROR), .Rx_DATA(Rx_DATA), .Rx_EN(Rx_EN), .baud_select(baud_select),
        .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
        .count(count), .overrun(overrun), .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt),
        .clr_status(clr_status)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [9:0] mq[$];
    int         m_perr, m_ferr;
    bit         m_ovr;
    logic [9:0] m_head;
    bit         m_prev_any;
    bit         accepting;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by the cycle about to be sampled, then step the clock.
    task automatic tick();
        bit any, ev, pop_ok, was_full;
        any = Rx_VALID | Rx_PERROR | Rx_FERROR;
        if (reset) begin
            mq.delete();
            m_perr = 0; m_ferr = 0; m_ovr = 0; m_head = '0; m_prev_any = 0;
        end else begin
            ev       = any && !m_prev_any && accepting;
            pop_ok   = rd_en && (mq.size() > 0);
            was_full = (mq.size() == DEPTH);
            if (clr_status) begin
                m_perr = 0; m_ferr = 0; m_ovr = 0;
            end
            if (pop_ok) void'(mq.pop_front());
            if (ev) begin
                if (Rx_PERROR) m_perr = (m_perr < 255) ? m_perr + 1 : 255;
                if (Rx_FERROR) m_ferr = (m_ferr < 255) ? m_ferr + 1 : 255;
                if (!(cfg_drop_errors && (Rx_PERROR || Rx_FERROR))) begin
                    if (was_full && !pop_ok) m_ovr = 1;
                    else mq.push_back({Rx_FERROR, Rx_PERROR, Rx_DATA});
                end
            end
            if (mq.size() > 0) m_head = mq[0];
            m_prev_any = any;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"},   32'(count),    32'(mq.size()));
        chk({tag, ".empty"},   32'(empty),    32'(mq.size() == 0));
        chk({tag, ".full"},    32'(full),     32'(mq.size() == DEPTH));
        chk({tag, ".rd_data"}, 32'(rd_data),  32'(m_head[7:0]));
        chk({tag, ".rd_err"},  32'(rd_err),   32'(m_head[9:8]));
        chk({tag, ".overrun"}, 32'(overrun),  32'(m_ovr));
        chk({tag, ".perr"},    32'(perr_cnt), 32'(m_perr));
        chk({tag, ".ferr"},    32'(ferr_cnt), 32'(m_ferr));
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic f);
        Rx_DATA = d; Rx_VALID = 1'b1; Rx_PERROR = p; Rx_FERROR = f;
        tick();
        Rx_VALID = 1'b0; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; cfg_enable = 1'b0; cfg_baud = 3'b000; cfg_drop_errors = 1'b0;
        Rx_VALID = 1'b0; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0; Rx_DATA = 8'h00;
        rd_en = 1'b0; clr_status = 1'b0; accepting = 0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset.rx_en", 32'(Rx_EN), 0);
        chk("reset.baud", 32'(baud_select), 0);
        check_model("reset");

        // Enable with baud 5
        cfg_enable = 1'b1; cfg_baud = 3'b101;
        tick();
        chk("enable.rx_en", 32'(Rx_EN), 1);
        chk("enable.baud", 32'(baud_select), 5);
        accepting = 1;
        check_model("enable");

        // Three clean frames, then pop them in order
        frame(8'h41, 0, 0);
        frame(8'h42, 0, 0);
        frame(8'h43, 0, 0);
        chk("three.count", 32'(count), 3);
        chk("three.head", 32'(rd_data), 32'h41);
        check_model("three");
        rd_en = 1'b1;
        tick(); chk("pop1.head", 32'(rd_data), 32'h42);
        tick(); chk("pop2.head", 32'(rd_data), 32'h43); chk("pop2.err", 32'(rd_err), 0);
        tick(); chk("pop3.empty", 32'(empty), 1);
        tick(); chk("underflow.count", 32'(count), 0); chk("underflow.hold", 32'(rd_data), 32'h43);
        rd_en = 1'b0;
        check_model("drain");

        // Parity error with and without dropping
        cfg_drop_errors = 1'b1;
        frame(8'h55, 1, 0);
        chk("drop.perr", 32'(perr_cnt), 1);
        chk("drop.count", 32'(count), 0);
        cfg_drop_errors = 1'b0;
        frame(8'h55, 1, 0);
        chk("keep.head", 32'(rd_data), 32'h55);
        chk("keep.err", 32'(rd_err), 32'h1);
        check_model("perr");
        rd_en = 1'b1; tick(); rd_en = 1'b0;

        // Overflow: five frames, no pops
        for (int i = 0; i < 5; i++) frame(8'hA0 + 8'(i), 0, 0);
        chk("ovf.full", 32'(full), 1);
        chk("ovf.overrun", 32'(overrun), 1);
        chk("ovf.head", 32'(rd_data), 32'hA0);
        Rx_DATA = 8'hA5; Rx_VALID = 1'b1; rd_en = 1'b1;
        tick();
        Rx_VALID = 1'b0; rd_en = 1'b0;
        chk("popwr.count", 32'(count), 4);
        chk("popwr.head", 32'(rd_data), 32'hA1);
        tick();
        check_model("popwr");
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("clr.overrun", 32'(overrun), 0);
        check_model("clr");

        // Baud change 5 -> 2 with a frame pulse during quiesce
        cfg_baud = 3'b010;
        tick();
        accepting = 0;
        n = 0;
        while (Rx_EN === 1'b0 && n < 64) begin
            n++;
            if (n == 2) chk("quiesce.baud_hold", 32'(baud_select), 5);
            if (n == 3) begin Rx_VALID = 1'b1; Rx_PERROR = 1'b1; Rx_DATA = 8'h77; end
            if (n == 4) begin Rx_VALID = 1'b0; Rx_PERROR = 1'b0; end
            tick();
        end
        accepting = 1;
        chk("quiesce.len", 32'(n), QC + 1);
        chk("quiesce.baud", 32'(baud_select), 2);
        check_model("quiesce");

        // Drain, then saturate the framing counter
        rd_en = 1'b1; repeat (4) tick(); rd_en = 1'b0;
        cfg_drop_errors = 1'b1;
        for (int i = 0; i < 300; i++) frame(8'(i), 0, 1);
        chk("sat.ferr", 32'(ferr_cnt), 255);
        check_model("sat");
        Rx_VALID = 1'b1; Rx_FERROR = 1'b1; clr_status = 1'b1;
        tick();
        Rx_VALID = 1'b0; Rx_FERROR = 1'b0; clr_status = 1'b0;
        chk("clr_ev.ferr", 32'(ferr_cnt), 1);
        check_model("clr_ev");
        tick();

        // Random traffic in RUN
        for (int i = 0; i < 2000; i++) begin
            cfg_drop_errors = ($urandom_range(0, 3) == 0);
            Rx_VALID   = ($urandom_range(0, 2) == 0);
            Rx_PERROR  = ($urandom_range(0, 5) == 0);
            Rx_FERROR  = ($urandom_range(0, 5) == 0);
            Rx_DATA    = 8'($urandom);
            rd_en      = (i < 1000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
            clr_status = ($urandom_range(0, 40) == 0);
            tick();
            chk("rnd.rx_en", 32'(Rx_EN), 1);
            check_model("rnd");
        end
        Rx_VALID = 1'b0; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;
        rd_en = 1'b0; clr_status = 1'b0; cfg_drop_errors = 1'b0;
        tick();

        // Reset mid-stream with two entries queued
        rd_en = 1'b1; repeat (5) tick(); rd_en = 1'b0;
        frame(8'h11, 0, 0);
        frame(8'h22, 0, 0);
        chk("pre_rst.count", 32'(count), 2);
        Rx_VALID = 1'b1; Rx_DATA = 8'h33; reset = 1'b1;
        accepting = 0;
        tick();
        reset = 1'b0; Rx_VALID = 1'b0;
        chk("rst.empty", 32'(empty), 1);
        chk("rst.rx_en", 32'(Rx_EN), 0);
        chk("rst.baud", 32'(baud_select), 0);
        check_model("rst");
        tick();
        chk("rearm.rx_en", 32'(Rx_EN), 1);
        chk("rearm.baud", 32'(baud_select), 2);
        accepting = 1;
        frame(8'h5A, 0, 0);
        check_model("rearm");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
